bt656_line_decoder: RTL and testbench

BT656_LINE_DECODER -- requirements
Module: bt656_line_decoder

---
 rtl/bt656_line_decoder_if.sv | 26 ++
 rtl/bt656_line_decoder.sv | 157 +++++++++++++++
 tb/tb_bt656_line_decoder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/bt656_line_decoder_if.sv
// Signal bundle between a BT656 byte source, the line decoder and the 5-line FIFO.
// The DUT uses the slave modport; the byte source/observer uses master.
interface bt656_line_decoder_if;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        write;
    logic        sol;
    logic        eol;
    logic [10:0] line_len;
    logic        field;
    logic        vblank;
    logic        trs_error;
    logic        overflow;
    logic [2:0]  state_dbg;

    // write is a single-cycle strobe: data_out, sol, eol (and line_len when eol) are valid only with it.
    modport master (
        output data_in,
        input  data_out, write, sol, eol, line_len, field, vblank, trs_error, overflow, state_dbg
    );

    modport slave (
        input  data_in,
        output data_out, write, sol, eol, line_len, field, vblank, trs_error, overflow, state_dbg
    );
endinterface

// File: rtl/bt656_line_decoder.sv
// BT656 line decoder: finds TRS/XY codes, extracts active-line bytes and writes them
// to a line FIFO with sol/eol markers, line length, field/vblank and error pulses.
module bt656_line_decoder #(
    parameter int MAX_LINE   = 1440,
    parameter bit CHECK_PROT = 1'b1
) (
    input logic                  clock,
    input logic                  reset_n,
    bt656_line_decoder_if.slave  bus
);
    typedef enum logic [2:0] {
        BLANK  = 3'd0,
        T1     = 3'd1,
        T2     = 3'd2,
        T3     = 3'd3,
        ACTIVE = 3'd4
    } state_t;

    localparam logic [10:0] MAX_CNT = 11'(MAX_LINE);

    state_t      state_q, state_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_q, pend_d;
    logic        first_q, first_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  dout_q, dout_d;
    logic        wr_q, wr_d;
    logic        sol_q, sol_d;
    logic        eol_q, eol_d;
    logic [10:0] len_q, len_d;
    logic        field_q, field_d;
    logic        vblank_q, vblank_d;
    logic        trs_q, trs_d;
    logic        ovf_q, ovf_d;

    logic [7:0]  din;
    logic        xy_f, xy_v, xy_h;
    logic        prot_ok, xy_ok;

    assign din     = bus.data_in;
    assign xy_f    = din[6];
    assign xy_v    = din[5];
    assign xy_h    = din[4];
    assign prot_ok = (din[3:0] == {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});
    assign xy_ok   = din[7] && (prot_ok || !CHECK_PROT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= BLANK;
            pend_vld_q <= 1'b0;
            pend_q     <= 8'd0;
            first_q    <= 1'b0;
            cnt_q      <= 11'd0;
            dout_q     <= 8'd0;
            wr_q       <= 1'b0;
            sol_q      <= 1'b0;
            eol_q      <= 1'b0;
            len_q      <= 11'd0;
            field_q    <= 1'b0;
            vblank_q   <= 1'b0;
            trs_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= pend_vld_d;
            pend_q     <= pend_d;
            first_q    <= first_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            sol_q      <= sol_d;
            eol_q      <= eol_d;
            len_q      <= len_d;
            field_q    <= field_d;
            vblank_q   <= vblank_d;
            trs_q      <= trs_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_vld_d = pend_vld_q;
        pend_d     = pend_q;
        first_d    = first_q;
        cnt_d      = cnt_q;
        dout_d     = dout_q;
        wr_d       = 1'b0;
        sol_d      = 1'b0;
        eol_d      = 1'b0;
        len_d      = len_q;
        field_d    = field_q;
        vblank_d   = vblank_q;
        trs_d      = 1'b0;
        ovf_d      = 1'b0;

        case (state_q)
            BLANK:  if (din == 8'hFF) state_d = T1;
            T1:     state_d = (din == 8'h00) ? T2 : BLANK;
            T2:     state_d = (din == 8'h00) ? T3 : BLANK;
            T3: begin
                state_d = BLANK;
                if (xy_ok) begin
                    field_d  = xy_f;
                    vblank_d = xy_v;
                    if (!xy_h && !xy_v) begin
                        state_d    = ACTIVE;
                        cnt_d      = 11'd0;
                        first_d    = 1'b1;
                        pend_vld_d = 1'b0;
                    end
                end else begin
                    trs_d = 1'b1;
                end
            end
            ACTIVE: begin
                // One byte is always held back so the line's last byte can carry eol.
                if (din == 8'hFF) begin
                    state_d = T1;
                    if (pend_vld_q) begin
                        wr_d       = 1'b1;
                        dout_d     = pend_q;
                        sol_d      = first_q;
                        eol_d      = 1'b1;
                        len_d      = cnt_q;
                        first_d    = 1'b0;
                        pend_vld_d = 1'b0;
                    end
                end else if (cnt_q == MAX_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    if (pend_vld_q) begin
                        wr_d    = 1'b1;
                        dout_d  = pend_q;
                        sol_d   = first_q;
                        first_d = 1'b0;
                    end
                    pend_d     = din;
                    pend_vld_d = 1'b1;
                    cnt_d      = cnt_q + 11'd1;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    assign bus.data_out  = dout_q;
    assign bus.write     = wr_q;
    assign bus.sol       = sol_q;
    assign bus.eol       = eol_q;
    assign bus.line_len  = len_q;
    assign bus.field     = field_q;
    assign bus.vblank    = vblank_q;
    assign bus.trs_error = trs_q;
    assign bus.overflow  = ovf_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_bt656_line_decoder.sv
// Directed bench for bt656_line_decoder: two instances (default parameters, and
// MAX_LINE=4 with protection checking off) see the same byte stream.
module tb_bt656_line_decoder;
    localparam int W = 21;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bt656_line_decoder_if ifa();
    bt656_line_decoder_if ifb();

    bt656_line_decoder #(.MAX_LINE(1440), .CHECK_PROT(1'b1)) u_a (
        .clock(clock), .reset_n(reset_n), .bus(ifa.slave));
    bt656_line_decoder #(.MAX_LINE(4), .CHECK_PROT(1'b0)) u_b (
        .clock(clock), .reset_n(reset_n), .bus(ifb.slave));

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int trs_a = 0, trs_b = 0, ovf_a = 0, ovf_b = 0;
    int sol_cyc_a = -1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [7:0] d, input logic s, input logic e,
                                          input logic [10:0] len);
        return {d, s, e, e ? len : 11'd0};
    endfunction

    // Monitors: pop one expected entry per write strobe.
    always @(negedge clock) begin
        if (reset_n) begin
            if (ifa.trs_error) trs_a++;
            if (ifa.overflow) ovf_a++;
            if (ifa.write) begin
                if (ifa.sol && sol_cyc_a < 0) sol_cyc_a = cyc;
                if (exp_a.size() == 0) check("a_unexpected_write", {24'd0, ifa.data_out}, 32'hFFFF_FFFF);
                else check("a_write", 32'(pack(ifa.data_out, ifa.sol, ifa.eol, ifa.line_len)),
                           32'(exp_a.pop_front()));
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (ifb.trs_error) trs_b++;
            if (ifb.overflow) ovf_b++;
            if (ifb.write) begin
                if (exp_b.size() == 0) check("b_unexpected_write", {24'd0, ifb.data_out}, 32'hFFFF_FFFF);
                else check("b_write", 32'(pack(ifb.data_out, ifb.sol, ifb.eol, ifb.line_len)),
                           32'(exp_b.pop_front()));
            end
        end
    end

    function automatic logic [31:0] outs_a();
        return {6'd0, ifa.data_out, ifa.write, ifa.sol, ifa.eol, ifa.line_len,
                ifa.field, ifa.vblank, ifa.trs_error, ifa.overflow};
    endfunction

    function automatic logic [31:0] outs_b();
        return {6'd0, ifb.data_out, ifb.write, ifb.sol, ifb.eol, ifb.line_len,
                ifb.field, ifb.vblank, ifb.trs_error, ifb.overflow};
    endfunction

    task automatic send(input logic [7:0] b);
        ifa.data_in = b;
        ifb.data_in = b;
        @(posedge clock);
        #1;
    endtask

    task automatic trs(input logic [7:0] xy);
        send(8'hFF); send(8'h00); send(8'h00); send(xy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(8'h00);
    endtask

    task automatic exp_both(input logic [7:0] d, input logic s, input logic e, input logic [10:0] len);
        exp_a.push_back(pack(d, s, e, len));
        exp_b.push_back(pack(d, s, e, len));
    endtask

    int s10;

    initial begin
        ifa.data_in = 8'h00;
        ifb.data_in = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("a_reset_outputs", outs_a(), 32'd0);
        check("b_reset_outputs", outs_b(), 32'd0);
        check("a_reset_state", {29'd0, ifa.state_dbg}, 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Normal 4-byte line, followed by EAV
        exp_both(8'h10, 1'b1, 1'b0, 11'd0);
        exp_both(8'h11, 1'b0, 1'b0, 11'd0);
        exp_both(8'h12, 1'b0, 1'b0, 11'd0);
        exp_both(8'h13, 1'b0, 1'b1, 11'd4);
        trs(8'h80);
        send(8'h10);
        s10 = cyc;
        send(8'h11); send(8'h12); send(8'h13);
        trs(8'h9D);
        idle(2);
        check("a_first_write_latency", {31'd0, (sol_cyc_a > s10)}, 32'd1);
        check("a_line_len_4", {21'd0, ifa.line_len}, 32'd4);
        check("a_queue_after_line", exp_a.size(), 32'd0);
        check("b_queue_after_line", exp_b.size(), 32'd0);

        // Vertical-blank SAV: no writes, vblank set
        trs(8'hAB);
        send(8'h20); send(8'h21); send(8'hFF); send(8'h10);
        idle(2);
        check("a_vblank_set", {31'd0, ifa.vblank}, 32'd1);
        check("b_vblank_set", {31'd0, ifb.vblank}, 32'd1);
        check("a_field_after_ab", {31'd0, ifa.field}, 32'd0);

        // One-byte line, then zero-byte line in field 1
        exp_both(8'h05, 1'b1, 1'b1, 11'd1);
        trs(8'h80);
        send(8'h05);
        trs(8'h9D);
        idle(2);
        check("a_line_len_1", {21'd0, ifa.line_len}, 32'd1);
        check("a_vblank_clear", {31'd0, ifa.vblank}, 32'd0);
        trs(8'hC7);
        check("a_field_1", {31'd0, ifa.field}, 32'd1);
        trs(8'hDA);
        idle(2);
        check("a_len_after_empty_line", {21'd0, ifa.line_len}, 32'd1);
        check("b_len_after_empty_line", {21'd0, ifb.line_len}, 32'd1);
        check("a_queue_after_empty", exp_a.size(), 32'd0);

        // Six-byte line: A keeps all, B saturates at 4 and drops 2
        for (int i = 0; i < 6; i++)
            exp_a.push_back(pack(8'(8'h41 + i), i == 0, i == 5, 11'd6));
        for (int i = 0; i < 4; i++)
            exp_b.push_back(pack(8'(8'h41 + i), i == 0, i == 3, 11'd4));
        trs(8'h80);
        for (int i = 0; i < 6; i++) send(8'(8'h41 + i));
        trs(8'h9D);
        idle(2);
        check("a_field_0", {31'd0, ifa.field}, 32'd0);
        check("a_overflow_count", ovf_a, 32'd0);
        check("b_overflow_count", ovf_b, 32'd2);
        check("a_line_len_6", {21'd0, ifa.line_len}, 32'd6);
        check("b_line_len_4", {21'd0, ifb.line_len}, 32'd4);
        check("a_queue_after_long", exp_a.size(), 32'd0);
        check("b_queue_after_long", exp_b.size(), 32'd0);

        // Bad protection bits: A rejects and holds vblank, B accepts
        trs(8'hAB);
        exp_b.push_back(pack(8'h50, 1'b1, 1'b0, 11'd0));
        exp_b.push_back(pack(8'h51, 1'b0, 1'b1, 11'd2));
        trs(8'h81);
        send(8'h50);
        check("a_vblank_held", {31'd0, ifa.vblank}, 32'd1);
        check("b_vblank_from_81", {31'd0, ifb.vblank}, 32'd0);
        check("a_state_blank_after_reject", {29'd0, ifa.state_dbg}, 32'd0);
        send(8'h51);
        trs(8'h9D);
        idle(2);
        check("a_trs_error_count", trs_a, 32'd1);
        check("b_trs_error_count", trs_b, 32'd0);
        check("b_line_len_2", {21'd0, ifb.line_len}, 32'd2);
        check("a_queue_after_reject", exp_a.size(), 32'd0);
        check("b_queue_after_reject", exp_b.size(), 32'd0);

        // Reset mid-line, raw bytes afterwards must produce nothing
        exp_both(8'h60, 1'b1, 1'b0, 11'd0);
        trs(8'h80);
        send(8'h60); send(8'h61);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("a_outputs_in_reset", outs_a(), 32'd0);
        check("b_outputs_in_reset", outs_b(), 32'd0);
        reset_n = 1'b1;
        send(8'h30); send(8'h31);
        idle(3);
        check("a_outputs_after_reset", outs_a(), 32'd0);
        check("b_outputs_after_reset", outs_b(), 32'd0);
        check("a_queue_after_reset", exp_a.size(), 32'd0);

        // Recovery line
        exp_both(8'h70, 1'b1, 1'b1, 11'd1);
        trs(8'h80);
        send(8'h70);
        trs(8'h9D);
        idle(3);
        check("a_queue_final", exp_a.size(), 32'd0);
        check("b_queue_final", exp_b.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
